// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown timer driven by keypad pulses.
// Digits are entered in ENTRY, latched into a preset on confirm, then counted down once per TICK_DIV cycles.
module countdown_ctrl #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keydown_num,
    input  logic [3:0] num,
    input  logic       keydown_clear,
    input  logic       keydown_confirm,
    input  logic       keydown_start,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic       running,
    output logic       expired
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {StEntry, StArmed, StRun, StPause, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    hi_q, hi_d, lo_q, lo_d;
    logic [3:0]    pre_hi_q, pre_hi_d, pre_lo_q, pre_lo_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, expired_q;
    logic          tick, done_now;
    logic [3:0]    dec_hi, dec_lo;

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        pre_hi_d = pre_hi_q;
        pre_lo_d = pre_lo_q;
        presc_d  = presc_q;
        tick     = (state_q == StRun) && (presc_q == PRESC_LAST);
        dec_lo   = (lo_q == 4'd0) ? 4'd9 : lo_q - 4'd1;
        dec_hi   = (lo_q == 4'd0) ? hi_q - 4'd1 : hi_q;
        done_now = tick && (dec_hi == 4'd0) && (dec_lo == 4'd0);

        if (keydown_clear) begin
            state_d  = StEntry;
            hi_d     = 4'd0;
            lo_d     = 4'd0;
            pre_hi_d = 4'd0;
            pre_lo_d = 4'd0;
            presc_d  = '0;
        end else begin
            // The RUN count advances regardless of which key arrives this cycle.
            if (state_q == StRun) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    hi_d = dec_hi;
                    lo_d = dec_lo;
                end
            end

            if (done_now) begin
                state_d = StDone;
            end else if (keydown_confirm) begin
                if (state_q == StEntry && (hi_q != 4'd0 || lo_q != 4'd0)) begin
                    pre_hi_d = hi_q;
                    pre_lo_d = lo_q;
                    state_d  = StArmed;
                end
            end else if (keydown_start) begin
                case (state_q)
                    StArmed: begin
                        state_d = StRun;
                        presc_d = '0;
                    end
                    StRun:   state_d = StPause;
                    StPause: state_d = StRun;
                    StDone: begin
                        hi_d    = pre_hi_q;
                        lo_d    = pre_lo_q;
                        state_d = StArmed;
                    end
                    default: ;
                endcase
            end else if (keydown_num && state_q == StEntry && num <= 4'd9) begin
                hi_d = lo_q;
                lo_d = num;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StEntry;
            hi_q      <= 4'd0;
            lo_q      <= 4'd0;
            pre_hi_q  <= 4'd0;
            pre_lo_q  <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pre_hi_q  <= pre_hi_d;
            pre_lo_q  <= pre_lo_d;
            presc_q   <= presc_d;
            running_q <= (state_d == StRun);
            expired_q <= (state_d == StDone);
        end
    end

    assign digit_hi = hi_q;
    assign digit_lo = lo_q;
    assign running  = running_q;
    assign expired  = expired_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus random key traffic, every cycle compared
// against an integer-valued behavioural model of the timer.
module tb_countdown_ctrl;

    localparam int unsigned TD = 4;
    localparam int M_ENTRY = 0, M_ARMED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       keydown_num = 1'b0, keydown_clear = 1'b0;
    logic       keydown_confirm = 1'b0, keydown_start = 1'b0;
    logic [3:0] num = 4'd0;
    logic [3:0] digit_hi, digit_lo;
    logic       running, expired;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: value kept as a plain integer 0..99, elapsed cycles within the current second.
    int m_mode = M_ENTRY, m_val = 0, m_preset = 0, m_ticks = 0;

    countdown_ctrl #(.TICK_DIV(TD)) dut (
        .clk            (clk),
        .rst            (rst),
        .keydown_num    (keydown_num),
        .num            (num),
        .keydown_clear  (keydown_clear),
        .keydown_confirm(keydown_confirm),
        .keydown_start  (keydown_start),
        .digit_hi       (digit_hi),
        .digit_lo       (digit_lo),
        .running        (running),
        .expired        (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] model_outs();
        logic [3:0] h, l;
        h = 4'(m_val / 10);
        l = 4'(m_val % 10);
        return {22'd0, h, l, m_mode == M_RUN, m_mode == M_DONE};
    endfunction

    function automatic void model_reset();
        m_mode = M_ENTRY; m_val = 0; m_preset = 0; m_ticks = 0;
    endfunction

    function automatic void model_step(input bit c, input bit cf, input bit st, input bit kn,
                                       input int n);
        if (c) begin
            model_reset();
            return;
        end
        if (m_mode == M_RUN) begin
            m_ticks++;
            if (m_ticks == TD) begin
                m_ticks = 0;
                m_val--;
                if (m_val == 0) begin
                    m_mode = M_DONE;
                    return;
                end
            end
        end
        if (cf) begin
            if (m_mode == M_ENTRY && m_val != 0) begin
                m_preset = m_val;
                m_mode   = M_ARMED;
            end
        end else if (st) begin
            if (m_mode == M_ARMED) begin
                m_mode = M_RUN; m_ticks = 0;
            end else if (m_mode == M_RUN) m_mode = M_PAUSE;
            else if (m_mode == M_PAUSE) m_mode = M_RUN;
            else if (m_mode == M_DONE) begin
                m_val = m_preset; m_mode = M_ARMED;
            end
        end else if (kn && m_mode == M_ENTRY && n <= 9) begin
            m_val = (m_val % 10) * 10 + n;
        end
    endfunction

    task automatic cyc(input bit c, input bit cf, input bit st, input bit kn, input int n);
        @(negedge clk);
        keydown_clear = c; keydown_confirm = cf; keydown_start = st; keydown_num = kn;
        num = 4'(n);
        @(posedge clk);
        model_step(c, cf, st, kn, n);
        #1;
        check("outs", {22'd0, digit_hi, digit_lo, running, expired}, model_outs());
        keydown_clear = 0; keydown_confirm = 0; keydown_start = 0; keydown_num = 0; num = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic key(input int n);   cyc(0, 0, 0, 1, n); endtask
    task automatic conf();             cyc(0, 1, 0, 0, 0); endtask
    task automatic start();            cyc(0, 0, 1, 0, 0); endtask
    task automatic clr();              cyc(1, 0, 0, 0, 0); endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_outs", {22'd0, digit_hi, digit_lo, running, expired}, 32'd0);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] shown();
        return {24'd0, digit_hi, digit_lo};
    endfunction

    initial begin
        #1;
        check("reset", {22'd0, digit_hi, digit_lo, running, expired}, 32'd0);
        #12 rst = 1'b0;

        // Basic countdown 12 -> 00
        key(1); key(2); conf(); start();
        check("start_val", shown(), 32'h12);
        check("start_run", {31'd0, running}, 32'd1);
        idle(4);
        check("first_dec", shown(), 32'h11);
        idle(44);
        check("end_val", shown(), 32'h00);
        check("end_flags", {30'd0, running, expired}, 32'b01);

        // Shift entry and illegal digit
        clr(); key(3); key(7); key(5);
        check("shift", shown(), 32'h75);
        key(10);
        check("bad_num", shown(), 32'h75);

        // Confirm with 00 ignored; BCD borrow
        clr(); conf();
        check("conf00", {30'd0, running, expired}, 32'd0);
        key(1); key(0); conf(); start(); idle(4);
        check("borrow", shown(), 32'h09);

        // Pause / resume
        clr(); key(0); key(5); conf(); start(); idle(1); start(); idle(20);
        check("frozen", shown(), 32'h05);
        check("paused", {31'd0, running}, 32'd0);
        start(); idle(1);
        check("resume1", shown(), 32'h05);
        idle(1);
        check("resume2", shown(), 32'h04);

        // Clear+num in RUN, reload from DONE
        clr(); key(1); conf(); start(); idle(1);
        cyc(1, 0, 0, 1, 7);
        check("clr_num", shown(), 32'h00);
        key(0); key(2); conf(); start(); idle(8);
        check("done", {31'd0, expired}, 32'd1);
        start();
        check("reload", shown(), 32'h02);
        check("armed", {30'd0, running, expired}, 32'd0);

        // Async reset mid-RUN, then first key honoured
        start(); idle(2);
        async_reset();
        idle(8);
        check("post_rst", shown(), 32'h00);
        key(3);
        check("first_key", shown(), 32'h03);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
